ping_trigger_gen: RTL and testbench
===================================

PING_TRIGGER_GEN -- requirements
Module: ping_trigger_gen

Interface
REQ-001 SHALL have parameter TRIG_CYCLES, default 10, meaning trigger pulse width in clk cycles (>=1).
REQ-002 SHALL have parameter WINDOW_CYCLES, default 100, meaning maximum measurement window in clk cycles (>=2).
REQ-003 SHALL have parameter HOLDOFF_CYCLES, default 20, meaning quiet gap after each window before the next ping (>=1).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port start  in  1  ping request, sampled only in IDLE.
REQ-007 SHALL have port echo  in  1  sensor echo, synchronous to clk; it is the same net as the distance counter's detect input.
REQ-008 SHALL have port trig  out  1  sensor trigger pulse.
REQ-009 SHALL have port dis_start  out  1  measurement window; drives the distance counter's disStart input.
REQ-010 SHALL have port busy  out  1  high in every state except IDLE.
REQ-011 SHALL have port done  out  1  one-cycle pulse when a window closes.
REQ-012 SHALL have port timeout  out  1  valid with done; 1 means no complete echo was seen.

Function
REQ-013 SHALL implement the FSM states IDLE, TRIG, WINDOW and HOLDOFF; all outputs SHALL be registered.
REQ-014 SHALL move from IDLE to TRIG on start=1; trig SHALL be high from the next cycle for exactly TRIG_CYCLES cycles.
REQ-015 SHALL move from TRIG to WINDOW after TRIG_CYCLES; dis_start SHALL rise in the cycle after trig falls, and trig and dis_start SHALL never be high together.
REQ-016 SHALL, in WINDOW, set an internal seen flag on the first cycle echo=1.
REQ-017 SHALL close the window on the first cycle echo=0 with the seen flag set: in the next cycle dis_start=0, done=1, timeout=0, and the state is HOLDOFF.
REQ-018 SHALL close the window after WINDOW_CYCLES cycles in WINDOW with no echo falling edge: in the next cycle dis_start=0, done=1, and timeout=1 if seen=0 or echo is still 1.
REQ-019 SHALL give the echo falling edge priority when it coincides with the last window cycle (timeout=0).
REQ-020 SHALL ignore echo high before WINDOW, so the seen flag is only set inside WINDOW.
REQ-021 SHALL hold the outputs low in HOLDOFF for HOLDOFF_CYCLES cycles, then return to IDLE; start SHALL be ignored while busy=1 (no queuing).
REQ-022 SHALL restart one counter on each state entry; the counter width SHALL be $clog2 of the largest parameter plus 1, with no wrap-around inside any state.
REQ-023 SHALL drive timeout=0 when done=0.

Reset
REQ-024 SHALL on rst_n=0 immediately force state=IDLE, trig=0, dis_start=0, busy=0, done=0, timeout=0, counter=0 and seen=0.
REQ-025 SHALL, on reset mid-operation, abandon the ping without a done pulse; the first start after rst_n rises SHALL be accepted normally.

Configuration
REQ-026 SHALL, when PING_AUTO_REPEAT_EN is defined, go from HOLDOFF directly to TRIG (continuous pinging) while start=1 at the end of HOLDOFF, and to IDLE otherwise.
REQ-027 SHALL, when PING_AUTO_REPEAT_EN is undefined, always go from HOLDOFF to IDLE, so a new start is needed for each ping.

Structure
REQ-028 SHALL place the state enum ping_state_t and the default parameter constants in the shared package ping_pkg.
REQ-029 SHALL use one sub-module, ping_timer: a loadable up-counter with a terminal-count flag, instantiated once.

Verification
REQ-030 SHALL cover: start pulse in IDLE -> trig high for 10 cycles, dis_start high from cycle 12.
REQ-031 SHALL cover: echo high for window cycles 5..34 -> dis_start falls in cycle 36 of the window; done=1, timeout=0.
REQ-032 SHALL cover: echo held at 0 throughout -> dis_start high for 100 cycles, then done=1, timeout=1, then 20 HOLDOFF cycles before IDLE.
REQ-033 SHALL cover: echo falling edge on window cycle 100 -> timeout=0; echo still high at cycle 100 -> timeout=1.
REQ-034 SHALL cover: rst_n low at window cycle 40 -> all outputs 0 at once, no done pulse, next start gives a normal ping.
REQ-035 SHALL cover: start held high with PING_AUTO_REPEAT_EN defined -> trig rises again in the cycle after HOLDOFF ends; without the macro -> returns to IDLE.

Source files
------------

// File: rtl/ping_pkg.sv
// Shared types and default timing constants for the ultrasonic ping trigger generator.
// Imported by ping_timer and ping_trigger_gen.
package ping_pkg;

   localparam int unsigned TRIG_CYCLES_DEF    = 10;
   localparam int unsigned WINDOW_CYCLES_DEF  = 100;
   localparam int unsigned HOLDOFF_CYCLES_DEF = 20;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_TRIG    = 2'd1,
      ST_WINDOW  = 2'd2,
      ST_HOLDOFF = 2'd3
   } ping_state_t;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ping_timer.sv
// Per-state cycle counter: restarts at zero, counts up and saturates at the terminal value.
// tc_o flags that the current cycle is the last one of the state.
module ping_timer
   import ping_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         restart_i,
   input  logic [W-1:0] term_i,
   output logic         tc_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   assign tc_o = (count_q == term_i);

   always_comb begin
      count_d = count_q;
      if (restart_i) begin
         count_d = '0;
      end else if (!tc_o) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/ping_trigger_gen.sv
// Ping sequencer: trigger pulse, echo measurement window, then a quiet holdoff.
// Define PING_AUTO_REPEAT_EN to chain pings directly from HOLDOFF while start is held.
module ping_trigger_gen
   import ping_pkg::*;
#(
   parameter int unsigned TRIG_CYCLES    = TRIG_CYCLES_DEF,
   parameter int unsigned WINDOW_CYCLES  = WINDOW_CYCLES_DEF,
   parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic echo,
   output logic trig,
   output logic dis_start,
   output logic busy,
   output logic done,
   output logic timeout
);

   localparam int unsigned CNT_W =
      $clog2(max3(TRIG_CYCLES, WINDOW_CYCLES, HOLDOFF_CYCLES)) + 1;

   localparam logic [CNT_W-1:0] TRIG_TERM    = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0] WINDOW_TERM  = CNT_W'(WINDOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLDOFF_TERM = CNT_W'(HOLDOFF_CYCLES - 1);

   ping_state_t      state_q, state_d;
   logic             seen_q, seen_d;
   logic             trig_q, trig_d;
   logic             dis_start_q, dis_start_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] term_sel;
   logic             tc;
   logic             close_win;

   ping_timer #(
      .W(CNT_W)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .restart_i (state_d != state_q),
      .term_i    (term_sel),
      .tc_o      (tc)
   );

   always_comb begin
      term_sel = '0;
      case (state_q)
         ST_TRIG:    term_sel = TRIG_TERM;
         ST_WINDOW:  term_sel = WINDOW_TERM;
         ST_HOLDOFF: term_sel = HOLDOFF_TERM;
         default:    term_sel = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      close_win = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_TRIG;
         end
         ST_TRIG: begin
            if (tc) state_d = ST_WINDOW;
         end
         ST_WINDOW: begin
            // A falling echo edge and the window limit both close the window.
            if ((seen_q && !echo) || tc) begin
               state_d   = ST_HOLDOFF;
               close_win = 1'b1;
            end
         end
         ST_HOLDOFF: begin
            if (tc) begin
`ifdef PING_AUTO_REPEAT_EN
               state_d = start ? ST_TRIG : ST_IDLE;
`else
               state_d = ST_IDLE;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_comb begin
      seen_d      = (state_q == ST_WINDOW && state_d == ST_WINDOW) ? (seen_q | echo) : 1'b0;
      trig_d      = (state_d == ST_TRIG);
      dis_start_d = (state_d == ST_WINDOW);
      busy_d      = (state_d != ST_IDLE);
      done_d      = close_win;
      timeout_d   = close_win && !(seen_q && !echo);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         seen_q      <= 1'b0;
         trig_q      <= 1'b0;
         dis_start_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         seen_q      <= seen_d;
         trig_q      <= trig_d;
         dis_start_q <= dis_start_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
      end
   end

   assign trig      = trig_q;
   assign dis_start = dis_start_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_ping_trigger_gen.sv
// Directed self-checking bench for ping_trigger_gen with default timing (10/100/20).
// Expected HOLDOFF exit behaviour follows PING_AUTO_REPEAT_EN when defined.
module tb_ping_trigger_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start = 1'b0;
   logic echo = 1'b0;
   logic trig, dis_start, busy, done, timeout;

   int checks = 0;
   int failures = 0;

   ping_trigger_gen #(
      .TRIG_CYCLES(10),
      .WINDOW_CYCLES(100),
      .HOLDOFF_CYCLES(20)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .echo      (echo),
      .trig      (trig),
      .dis_start (dis_start),
      .busy      (busy),
      .done      (done),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From IDLE: pulse start, hold echo at pre_echo during TRIG; returns in window cycle 1.
   task automatic start_ping(input logic pre_echo);
      start = 1'b1;
      echo  = pre_echo;
      tick();
      start = 1'b0;
      repeat (10) tick();
      echo = 1'b0;
   endtask

   // From window cycle 1: echo high for cycles lo..hi; returns in the cycle done is seen.
   task automatic run_window(input int lo, input int hi,
                             output int done_k, output logic to_v, output logic bad);
      done_k = 0;
      to_v   = 1'b0;
      bad    = 1'b0;
      for (int k = 1; k <= 130 && done_k == 0; k++) begin
         echo = (k >= lo && k <= hi);
         if (done === 1'b1) begin
            done_k = k;
            to_v   = timeout;
            if (dis_start !== 1'b0 || trig !== 1'b0) bad = 1'b1;
         end else begin
            if (dis_start !== 1'b1 || timeout !== 1'b0 || trig !== 1'b0) bad = 1'b1;
            tick();
         end
      end
      echo = 1'b0;
   endtask

   task automatic wait_idle(output int n, output int done_cnt);
      n = 0;
      done_cnt = 0;
      while (busy === 1'b1 && n < 40) begin
         tick();
         n++;
         if (done !== 1'b0 || trig !== 1'b0 || dis_start !== 1'b0) done_cnt++;
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({trig, dis_start, busy, done, timeout} !== 5'b0) begin
         failures++;
         $display("FAIL reset_async: got %b expected 00000", {trig, dis_start, busy, done, timeout});
      end
      start = 1'b1;
      repeat (3) tick();
      checks++;
      if ({trig, dis_start, busy, done, timeout} !== 5'b0) begin
         failures++;
         $display("FAIL reset_hold: got %b expected 00000", {trig, dis_start, busy, done, timeout});
      end
      start = 1'b0;
      rst_n = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || trig !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_idle: got busy=%b trig=%b expected 0 0", busy, trig);
      end
   endtask

   task automatic test_trig();
      int dk, n, dc;
      logic tv, bad;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         checks++;
         if (trig !== 1'b1 || dis_start !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL trig_cycle_%0d: got trig=%b dis=%b busy=%b expected 1 0 1", i, trig, dis_start, busy);
         end
         tick();
      end
      checks++;
      if (trig !== 1'b0 || dis_start !== 1'b1) begin
         failures++;
         $display("FAIL dis_start_rise: got trig=%b dis=%b expected 0 1", trig, dis_start);
      end
      run_window(1000, 0, dk, tv, bad);
      wait_idle(n, dc);
   endtask

   task automatic test_echo_window();
      int dk, n, dc;
      logic tv, bad;
      start_ping(1'b0);
      run_window(5, 34, dk, tv, bad);
      checks++;
      if (dk != 36 || tv !== 1'b0) begin
         failures++;
         $display("FAIL echo_close: got cycle=%0d timeout=%b expected 36 0", dk, tv);
      end
      checks++;
      if (bad !== 1'b0) begin
         failures++;
         $display("FAIL echo_window_outputs: got bad=%b expected 0", bad);
      end
      wait_idle(n, dc);
      checks++;
      if (n != 20 || dc != 0) begin
         failures++;
         $display("FAIL echo_holdoff: got len=%0d extra=%0d expected 20 0", n, dc);
      end
   endtask

   task automatic test_short_echo();
      int dk, n, dc;
      logic tv, bad;
      start_ping(1'b0);
      run_window(1, 1, dk, tv, bad);
      checks++;
      if (dk != 3 || tv !== 1'b0 || bad !== 1'b0) begin
         failures++;
         $display("FAIL short_echo: got cycle=%0d timeout=%b bad=%b expected 3 0 0", dk, tv, bad);
      end
      wait_idle(n, dc);
   endtask

   task automatic test_timeout();
      int dk, n, dc;
      logic tv, bad;
      start_ping(1'b0);
      run_window(1000, 0, dk, tv, bad);
      checks++;
      if (dk != 101 || tv !== 1'b1 || bad !== 1'b0) begin
         failures++;
         $display("FAIL timeout_close: got cycle=%0d timeout=%b bad=%b expected 101 1 0", dk, tv, bad);
      end
      tick();
      checks++;
      if (done !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1 || dis_start !== 1'b0) begin
         failures++;
         $display("FAIL holdoff_outputs: got done=%b to=%b busy=%b dis=%b expected 0 0 1 0", done, timeout, busy, dis_start);
      end
      repeat (8) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle(n, dc);
      checks++;
      if (n != 10 || dc != 0) begin
         failures++;
         $display("FAIL timeout_holdoff: got remaining=%0d extra=%0d expected 10 0", n, dc);
      end
      tick();
      checks++;
      if (trig !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL no_queue: got trig=%b busy=%b expected 0 0", trig, busy);
      end
   endtask

   task automatic test_last_cycle();
      int dk, n, dc;
      logic tv, bad;
      start_ping(1'b0);
      run_window(50, 99, dk, tv, bad);
      checks++;
      if (dk != 101 || tv !== 1'b0 || bad !== 1'b0) begin
         failures++;
         $display("FAIL edge_on_last: got cycle=%0d timeout=%b bad=%b expected 101 0 0", dk, tv, bad);
      end
      wait_idle(n, dc);
      start_ping(1'b0);
      run_window(50, 200, dk, tv, bad);
      checks++;
      if (dk != 101 || tv !== 1'b1 || bad !== 1'b0) begin
         failures++;
         $display("FAIL echo_high_last: got cycle=%0d timeout=%b bad=%b expected 101 1 0", dk, tv, bad);
      end
      wait_idle(n, dc);
   endtask

   task automatic test_pre_window_echo();
      int dk, n, dc;
      logic tv, bad;
      start_ping(1'b1);
      run_window(1000, 0, dk, tv, bad);
      checks++;
      if (dk != 101 || tv !== 1'b1 || bad !== 1'b0) begin
         failures++;
         $display("FAIL pre_window_echo: got cycle=%0d timeout=%b bad=%b expected 101 1 0", dk, tv, bad);
      end
      wait_idle(n, dc);
   endtask

   task automatic test_mid_reset();
      int dk, n, dc, stray;
      logic tv, bad;
      start_ping(1'b0);
      for (int k = 1; k <= 39; k++) begin
         echo = (k >= 5);
         tick();
      end
      echo = 1'b1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({trig, dis_start, busy, done, timeout} !== 5'b0) begin
         failures++;
         $display("FAIL mid_reset_outputs: got %b expected 00000", {trig, dis_start, busy, done, timeout});
      end
      repeat (2) tick();
      echo = 1'b0;
      rst_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (done !== 1'b0 || busy !== 1'b0) stray++;
      end
      checks++;
      if (stray != 0) begin
         failures++;
         $display("FAIL mid_reset_no_done: got stray=%0d expected 0", stray);
      end
      start_ping(1'b0);
      run_window(5, 34, dk, tv, bad);
      checks++;
      if (dk != 36 || tv !== 1'b0 || bad !== 1'b0) begin
         failures++;
         $display("FAIL after_reset_ping: got cycle=%0d timeout=%b bad=%b expected 36 0 0", dk, tv, bad);
      end
      wait_idle(n, dc);
   endtask

   task automatic test_back_to_back();
      int dk;
      logic tv, bad;
      start = 1'b1;
      tick();
      repeat (10) tick();
      run_window(1000, 0, dk, tv, bad);
      checks++;
      if (dk != 101 || tv !== 1'b1) begin
         failures++;
         $display("FAIL held_start_window: got cycle=%0d timeout=%b expected 101 1", dk, tv);
      end
      repeat (19) tick();
      checks++;
      if (busy !== 1'b1 || trig !== 1'b0) begin
         failures++;
         $display("FAIL holdoff_last: got busy=%b trig=%b expected 1 0", busy, trig);
      end
      tick();
`ifdef PING_AUTO_REPEAT_EN
      checks++;
      if (trig !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL auto_repeat: got trig=%b busy=%b expected 1 1", trig, busy);
      end
`else
      checks++;
      if (trig !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL return_idle: got trig=%b busy=%b expected 0 0", trig, busy);
      end
      tick();
      checks++;
      if (trig !== 1'b1) begin
         failures++;
         $display("FAIL restart_from_idle: got trig=%b expected 1", trig);
      end
`endif
      start = 1'b0;
   endtask

   initial begin
      test_reset();
      test_trig();
      test_echo_window();
      test_short_echo();
      test_timeout();
      test_last_cycle();
      test_pre_window_echo();
      test_mid_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
